// File: rtl/line_window_ctrl_if.sv
// line_window_ctrl_if: pixel stream in, 3x3 window stream out, plus status flags
interface line_window_ctrl_if;
    logic [7:0]  pixel_data;
    logic        pixel_data_valid;
    logic [71:0] window_data;
    logic        window_data_valid;
    logic        window_ready;
    logic        intr;
    logic        overflow;

    modport master (
        output pixel_data, pixel_data_valid, window_ready,
        input  window_data, window_data_valid, intr, overflow
    );

    modport slave (
        input  pixel_data, pixel_data_valid, window_ready,
        output window_data, window_data_valid, intr, overflow
    );
endinterface

// File: rtl/line_window_ctrl.sv
// line_window_ctrl: 4-line ring buffer that streams 3x3 pixel windows to the Sobel stage
module line_window_ctrl #(
    parameter int IMG_WIDTH = 512,
    parameter int COL_W     = 9
) (
    input logic               axi_clk,
    input logic               axi_reset_n,
    line_window_ctrl_if.slave bus
);
    localparam int CI = $clog2(IMG_WIDTH);
    localparam int FW = COL_W + 3;

    typedef enum logic {IDLE, READ} state_t;

    state_t           state, next_state;
    logic [7:0]       mem [4][IMG_WIDTH];
    logic [1:0]       wr_line, rd_line;
    logic [COL_W-1:0] wr_col, rd_col;
    logic [FW-1:0]    fill_cnt;
    logic [71:0]      win, window_q;
    logic             valid_q, intr_q, overflow_q;
    logic             wr_en, wr_last, rd_fire, rd_last;

    assign wr_en   = bus.pixel_data_valid && fill_cnt != FW'(4*IMG_WIDTH);
    assign wr_last = wr_col == COL_W'(IMG_WIDTH-1);
    assign rd_last = rd_col == COL_W'(IMG_WIDTH-1);

    // Window taps: cx is the column offset by one so that cx==0 is the left pad and cx>IMG_WIDTH the right pad
    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            logic [1:0]     ln;
            logic [COL_W:0] cx;
            assign ln = rd_line + 2'(r);
            assign cx = {1'b0, rd_col} + (COL_W+1)'(c);
            assign win[8*(3*r+c) +: 8] = (cx == '0 || cx > (COL_W+1)'(IMG_WIDTH)) ? 8'd0 : mem[ln][CI'(cx - 1'b1)];
        end
    end

    // Line storage has no reset; reads see the pre-write contents in the cycle of a write
    always_ff @(posedge axi_clk) begin
        if (wr_en) mem[wr_line][CI'(wr_col)] <= bus.pixel_data;
    end

    // Write pointer advance and sticky overflow when a pixel arrives with the ring full
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            wr_col     <= '0;
            wr_line    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_col  <= wr_last ? '0 : wr_col + 1'b1;
                wr_line <= wr_line + 2'(wr_last);
            end
            if (bus.pixel_data_valid && !wr_en) overflow_q <= 1'b1;
        end
    end

    // Occupancy: pixels stored minus windows read
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) fill_cnt <= '0;
        else fill_cnt <= fill_cnt + FW'(wr_en) - FW'(rd_fire);
    end

    // FSM state register
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) state <= IDLE;
        else state <= next_state;
    end

    // FSM next state: start a line once three lines are buffered, stop after its last column
    always_comb begin
        next_state = (state == IDLE) ? (fill_cnt >= FW'(3*IMG_WIDTH) ? READ : IDLE)
                                     : (rd_fire && rd_last ? IDLE : READ);
    end

    // FSM output: a read fires whenever the output register is empty or being drained
    always_comb begin
        rd_fire = state == READ && (!valid_q || bus.window_ready);
    end

    // Read pointer: column restarts on entering a line, line advances after the last column
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            rd_col  <= '0;
            rd_line <= '0;
        end else if (state == IDLE) begin
            rd_col <= '0;
        end else if (rd_fire) begin
            rd_col  <= rd_last ? '0 : rd_col + 1'b1;
            rd_line <= rd_line + 2'(rd_last);
        end
    end

    // Output register: load on read, hold under back-pressure, clear valid on accept
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            window_q <= '0;
            valid_q  <= 1'b0;
            intr_q   <= 1'b0;
        end else begin
            if (rd_fire) begin
                window_q <= win;
                valid_q  <= 1'b1;
            end else if (bus.window_ready) begin
                valid_q <= 1'b0;
            end
            intr_q <= rd_fire && rd_last;
        end
    end

    assign bus.window_data       = window_q;
    assign bus.window_data_valid = valid_q;
    assign bus.intr              = intr_q;
    assign bus.overflow          = overflow_q;
endmodule

// File: tb/tb_line_window_ctrl.sv
// tb_line_window_ctrl: table and scoreboard driven check of the line window controller
module tb_line_window_ctrl;
    localparam int W = 8;

    typedef struct {int col; logic [71:0] d;} exp_t;
    typedef struct {int top; int col; logic [71:0] exp;} vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_window_ctrl_if bus();
    line_window_ctrl #(.IMG_WIDTH(W), .COL_W(3)) dut (.axi_clk(clk), .axi_reset_n(rst_n), .bus(bus));

    exp_t q[$];
    vec_t tbl[W];
    int compared = 0, mismatched = 0, intr_cnt = 0, pops = 0, cyc = 0, last_cyc = 0;

    function automatic logic [7:0] pix(int r, int c);
        return 8'(16*r + c + 1);
    endfunction

    // Expected window centred on row top+1; patch models row 0 col 0 overwritten by pixel 0x41
    function automatic logic [71:0] win(int top, int col, bit patch);
        logic [71:0] w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                int cc = col + c - 1;
                if (cc >= 0 && cc < W) w[8*(3*r+c) +: 8] = (patch && top + r == 0 && cc == 0) ? 8'h41 : pix(top + r, cc);
            end
        return w;
    endfunction

    task automatic chk(string name, logic [71:0] act, logic [71:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic mon();
        exp_t e;
        cyc++;
        if (bus.window_data_valid && bus.window_ready) begin
            if (q.size() == 0) chk("unexpected_window", 72'(bus.window_data_valid), '0);
            else begin
                e = q.pop_front();
                chk("window", bus.window_data, e.d);
                chk("intr_with_last", 72'(bus.intr), 72'(e.col == W-1));
                if (e.col != 0) chk("back_to_back", 72'(cyc), 72'(last_cyc + 1));
                last_cyc = cyc;
                pops++;
            end
        end else if (bus.intr) chk("stray_intr", 72'(bus.intr), '0);
        if (bus.intr) intr_cnt++;
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n) mon();
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(int r);
        for (int c = 0; c < W; c++) begin
            bus.pixel_data = pix(r, c);
            bus.pixel_data_valid = 1'b1;
            tick();
        end
        bus.pixel_data_valid = 1'b0;
        bus.pixel_data = '0;
    endtask

    task automatic push_tbl();
        for (int i = 0; i < W; i++) q.push_back('{tbl[i].col, tbl[i].exp});
    endtask

    task automatic wait_intr(int n);
        for (int i = 0; i < 200 && intr_cnt < n; i++) tick();
        chk("intr_wait", 72'(intr_cnt >= n), 72'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) tick();
        chk("drain", 72'(q.size()), '0);
        repeat (5) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.pixel_data_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        q.delete();
        intr_cnt = 0;
        pops = 0;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.pixel_data = '0;
        bus.pixel_data_valid = 1'b0;
        bus.window_ready = 1'b1;
        for (int i = 0; i < W; i++) tbl[i] = '{0, i, win(0, i, 0)};
        tbl[0].exp   = 72'h22_21_00_12_11_00_02_01_00;
        tbl[W-1].exp = 72'h00_28_27_00_18_17_00_08_07;
        // 1: reset held while valid toggles
        for (int i = 0; i < 6; i++) begin
            bus.pixel_data = 8'hA5;
            bus.pixel_data_valid = 1'(i % 2);
            tick();
            chk("reset_window", bus.window_data, '0);
            chk("reset_flags", 72'({bus.window_data_valid, bus.intr, bus.overflow}), '0);
        end
        bus.pixel_data_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("fill_after_reset", 72'(dut.fill_cnt), '0);
        // 2: two lines are not enough for a window
        send_row(0);
        send_row(1);
        repeat (10) tick();
        chk("no_window_2_lines", 72'(bus.window_data_valid), '0);
        chk("no_intr_2_lines", 72'(intr_cnt), '0);
        // 3: third line releases one full output line
        push_tbl();
        send_row(2);
        drain();
        chk("intr_count_line", 72'(intr_cnt), 72'(1));
        // 4: six input lines, rows 4 and 5 sent only after a line buffer is freed
        do_reset();
        for (int l = 0; l < 4; l++)
            for (int c = 0; c < W; c++) q.push_back('{c, win(l, c, 0)});
        for (int r = 0; r < 4; r++) send_row(r);
        wait_intr(1);
        send_row(4);
        wait_intr(2);
        send_row(5);
        drain();
        chk("intr_count_4_lines", 72'(intr_cnt), 72'(4));
        chk("no_overflow_4_lines", 72'(bus.overflow), '0);
        // 5: back-pressure; the empty output register takes one window, freeing one slot,
        // so pixel 33 (row 4 col 0) lands in line 0 col 0 and pixel 34 is the first dropped
        bus.window_ready = 1'b0;
        do_reset();
        for (int c = 0; c < W; c++) q.push_back('{c, win(0, c, c != 0)});
        for (int c = 0; c < W; c++) q.push_back('{c, win(1, c, 0)});
        for (int i = 0; i < 32; i++) begin
            bus.pixel_data = pix(i / W, i % W);
            bus.pixel_data_valid = 1'b1;
            tick();
        end
        bus.pixel_data = pix(4, 0);
        tick();
        chk("overflow_at_33", 72'(bus.overflow), '0);
        bus.pixel_data = pix(4, 1);
        tick();
        chk("overflow_at_34", 72'(bus.overflow), 72'(1));
        bus.pixel_data_valid = 1'b0;
        repeat (5) tick();
        chk("held_window", bus.window_data, win(0, 0, 0));
        chk("held_valid", 72'(bus.window_data_valid), 72'(1));
        chk("no_accept_stalled", 72'(pops), '0);
        bus.window_ready = 1'b1;
        drain();
        chk("resumed_windows", 72'(pops), 72'(16));
        chk("overflow_sticky", 72'(bus.overflow), 72'(1));
        chk("intr_count_stall", 72'(intr_cnt), 72'(2));
        // 6: reset while the window for column 3 is on the output (read pointer at column 4)
        do_reset();
        push_tbl();
        for (int r = 0; r < 3; r++) send_row(r);
        for (int i = 0; i < 100 && pops < 3; i++) tick();
        chk("reach_col4", 72'(pops), 72'(3));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_window", bus.window_data, '0);
        chk("async_reset_flags", 72'({bus.window_data_valid, bus.intr, bus.overflow}), '0);
        q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        intr_cnt = 0;
        pops = 0;
        tick();
        send_row(0);
        send_row(1);
        push_tbl();
        send_row(2);
        drain();
        chk("rerun_windows", 72'(pops), 72'(W));
        chk("rerun_intr", 72'(intr_cnt), 72'(1));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
